ysyx_mdu: RTL
=============

Name: ysyx_mdu

Overview:
Iterative RV32M multiply/divide unit for the ysyx core. It sits beside the single-cycle ALU in the execute stage and serves the instructions the ALU cannot: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU. The decode/issue stage launches an operation through a valid/ready request port and stalls until the result handshake completes on the response port.

Parameters:
XLEN, 32, operand/result width; only 32 is supported. The iteration counter is clog2(XLEN)+1 bits wide.

Ports:
clk  in  1  clock, all state updates on its rising edge
rst  in  1  synchronous active-high reset
flush  in  1  abort any in-flight operation (pipeline redirect)
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request
src_a  in  32  rs1 operand (multiplicand / dividend)
src_b  in  32  rs2 operand (multiplier / divisor)
func  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  32  operation result

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, counter=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE to BUSY: on in_valid&in_ready. Latch the operands, func, and sign flags. Convert signed operands to magnitudes. Counter=0.
  - IDLE to DONE: used for special cases with 1-edge latency (see below).
  - BUSY: one iteration per cycle.
    - Multiply: shift-add, 64-bit accumulator.
    - Divide: restoring, 32-bit remainder and quotient.
    - BUSY to DONE: after the 32nd iteration edge, with the sign-corrected result written to the result register.
  - DONE: out_valid=1 and result held stable. DONE to IDLE on out_ready.
- in_ready=1 only in IDLE. No new request is accepted in BUSY or DONE, including the cycle in which the DONE handshake occurs.
- Latency:
  - Normal ops: out_valid rises 32 edges after the accepting edge.
  - Special cases: out_valid rises 1 edge after the accepting edge.
- Signedness:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: src_a signed, src_b unsigned.
  - MULHU/DIVU/REMU: unsigned.
- Result selection:
  - MUL returns product[31:0]; MULH* return product[63:32]. The product is negated when the operand signs differ.
  - Quotient is negated when the dividend and divisor signs differ. Remainder takes the sign of the dividend.
- Special cases, resolved in IDLE without iteration:
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give src_a.
  - Signed overflow (src_a=0x80000000, src_b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - Magnitude 0x80000000 is handled as an unsigned 32-bit value, so no overflow arises in the iteration.
- Backpressure: while out_ready=0 in DONE, out_valid and result stay constant indefinitely.
- flush:
  - In any state, the next edge goes to IDLE with out_valid=0. The result of the aborted op is discarded.
  - flush overrides a simultaneous in_valid (no accept) and a simultaneous out_ready.
- rst mid-operation: same effect as flush, and additionally result=0.
- in_valid must stay asserted with stable operands until it is accepted. The unit samples only on the accepting edge.
- result is updated only on entry to DONE. Outside DONE it holds its last value, which is don't-care.

Decomposition:
- Shared package (or ysyx_defs include):
  - funct3 constants MDU_MUL..MDU_REMU
  - FSM state encoding
  - XLEN
- One natural sub-module, ysyx_mdu_div_step: combinational single restoring-division step. Inputs: remainder, quotient, divisor. Outputs: next remainder/quotient.
- The multiply step stays inline in the top module.

Test Plan:
- MUL 7×6, out_ready=1: in_ready drops after accept; out_valid exactly 32 edges later; result=0x0000002A; in_ready=1 the edge after the handshake.
- MULH 0xFFFFFFFF×0xFFFFFFFF gives 0x00000000. MULHU on the same operands gives 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0x00000002 gives 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (−7)/2 gives 0xFFFFFFFD. REM on the same operands gives 0xFFFFFFFF. DIVU 100/7 gives 14. REMU 100/7 gives 2.
- Special cases (each with out_valid 1 edge after accept):
  - DIV 5/0 gives 0xFFFFFFFF.
  - REMU 5/0 gives 5.
  - DIV 0x80000000/0xFFFFFFFF gives 0x80000000.
  - REM on the same operands gives 0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. out_valid stays 1, result stays stable, and in_ready stays 0 throughout. Raise out_ready; the unit returns to IDLE on the next edge.
- Abort: assert flush at iteration 10 of a DIV. The next edge gives IDLE and out_valid=0. A new MUL 3×3 then gives 9 after 32 edges. Repeat the test with rst in place of flush: same behaviour, and result=0 after reset.

Source files
------------

// File: rtl/ysyx_mdu_pkg.sv
// ==== ysyx_mdu_pkg : shared constants and types for the RV32M multiply/divide unit ====
// ==== rev 1.0 ====
`default_nettype none

package ysyx_mdu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_t;

endpackage

`default_nettype wire

// File: rtl/ysyx_mdu_div_step.sv
// ==== ysyx_mdu_div_step : one combinational restoring-division step ====
// ==== rev 1.0 ====
`default_nettype none

module ysyx_mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nx,
  output logic [XLEN-1:0] quo_nx
);
  import ysyx_mdu_pkg::*;

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Dividend bits are consumed MSB-first out of quo while quotient bits enter at the LSB.
  assign shifted = {rem, quo[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor};
  assign rem_nx  = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
  assign quo_nx  = {quo[XLEN-2:0], ~diff[XLEN]};

endmodule

`default_nettype wire

// File: rtl/ysyx_mdu.sv
// ==== ysyx_mdu : iterative RV32M multiply/divide unit, valid/ready in and out ====
// ==== rev 1.0 ====
`default_nettype none

module ysyx_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [2:0]      func,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);
  import ysyx_mdu_pkg::*;

  localparam int CNT_W = $clog2(XLEN) + 1;

  mdu_state_t        state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic              neg_a, neg_b;
  logic [XLEN-1:0]   opb;
  logic [2*XLEN-1:0] acc;

  logic            sgn_a, sgn_b, in_neg_a, in_neg_b;
  logic [XLEN-1:0] mag_a, mag_b, special_res;
  logic            div_zero, div_ovf, special, accept, last;

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);

  assign sgn_a    = !(func == MDU_MULHU || func == MDU_DIVU || func == MDU_REMU);
  assign sgn_b    = sgn_a && (func != MDU_MULHSU);
  assign in_neg_a = sgn_a & src_a[XLEN-1];
  assign in_neg_b = sgn_b & src_b[XLEN-1];
  // 0x80000000 negates to itself, which is the correct unsigned magnitude.
  assign mag_a    = in_neg_a ? -src_a : src_a;
  assign mag_b    = in_neg_b ? -src_b : src_b;

  assign div_zero = func[2] && (src_b == '0);
  assign div_ovf  = func[2] && !func[0] && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (&src_b);
  assign special  = div_zero | div_ovf;
  always_comb begin
    special_res = '0;
    if (div_zero) special_res = func[1] ? src_a : '1;
    else          special_res = func[1] ? '0 : src_a;
  end

  assign accept = in_valid && in_ready && !flush;
  assign last   = (cnt == CNT_W'(XLEN - 1));

  // Multiply: {hi, lo} starts as {0, multiplier}; add multiplicand into hi on lo[0], shift right.
  logic [XLEN:0]     mul_hi;
  logic [2*XLEN-1:0] mul_nx;
  assign mul_hi = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
  assign mul_nx = {mul_hi, acc[XLEN-1:1]};

  logic [XLEN-1:0] rem_nx, quo_nx;
  ysyx_mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem     (acc[2*XLEN-1:XLEN]),
    .quo     (acc[XLEN-1:0]),
    .divisor (opb),
    .rem_nx  (rem_nx),
    .quo_nx  (quo_nx)
  );

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, final_res;
  assign prod_s = (neg_a ^ neg_b) ? -mul_nx : mul_nx;
  assign quo_s  = (neg_a ^ neg_b) ? -quo_nx : quo_nx;
  assign rem_s  = neg_a ? -rem_nx : rem_nx;

  always_comb begin
    final_res = '0;
    if (op[2])              final_res = op[1] ? rem_s : quo_s;
    else if (op == MDU_MUL) final_res = prod_s[XLEN-1:0];
    else                    final_res = prod_s[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = special ? ST_DONE : ST_BUSY;
      ST_BUSY: if (last) state_nx = ST_DONE;
      ST_DONE: if (out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
    if (flush) state_nx = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      result <= '0;
      acc    <= '0;
      opb    <= '0;
      op     <= '0;
      neg_a  <= 1'b0;
      neg_b  <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op    <= func;
            neg_a <= in_neg_a;
            neg_b <= in_neg_b;
            cnt   <= '0;
            acc   <= func[2] ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
            opb   <= func[2] ? mag_b : mag_a;
            if (special) result <= special_res;
          end
        end
        ST_BUSY: begin
          acc <= op[2] ? {rem_nx, quo_nx} : mul_nx;
          cnt <= cnt + 1'b1;
          if (last) result <= final_res;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
